// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared definitions for the register-file dump sequencer: FSM state
// encodings, byte-count derivation and the on-wire byte order.
package regfile_dump_ctrl_pkg;

  // 3-bit state encodings; S_CKSUM is only reachable with REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STALL = 3'd1,
    S_LATCH = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4,
    S_CKSUM = 3'd5
  } state_t;

  // Registers go out most-significant byte first
  localparam bit MSB_FIRST = 1'b1;

  // Bytes per register word
  function automatic int nbytes_of(input int b);
    return b / 8;
  endfunction

endpackage

// File: rtl/regfile_dump_ctrl_word_byte_serializer.sv
// Word-to-byte serializer with a valid/ready output stage.
// A load pulse captures a word and starts streaming; 'single' limits the
// word to its first byte (used for the checksum byte). last_accept is
// high in the cycle the final byte is handed off.
module word_byte_serializer
  import regfile_dump_ctrl_pkg::*;
#(
  parameter int B = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         single,
  input  logic [B-1:0] load_data,
  input  logic         tx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  output logic         last_accept
);
  localparam int NBYTES = nbytes_of(B);
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [B-1:0]  shift_reg;
  logic [CW-1:0] byte_cnt;
  logic [CW-1:0] last_cnt;
  logic          accept;

  assign accept      = tx_valid & tx_ready;
  assign last_accept = accept && (byte_cnt == last_cnt);
  assign tx_data     = MSB_FIRST ? shift_reg[B-1 -: 8] : shift_reg[7:0];

  // Load has priority so a new word can follow the final accept back-to-back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      byte_cnt  <= '0;
      last_cnt  <= '0;
      tx_valid  <= 1'b0;
    end else if (load) begin
      shift_reg <= load_data;
      byte_cnt  <= '0;
      last_cnt  <= single ? '0 : CW'(NBYTES - 1);
      tx_valid  <= 1'b1;
    end else if (accept) begin
      shift_reg <= MSB_FIRST ? (shift_reg << 8) : (shift_reg >> 8);
      byte_cnt  <= byte_cnt + CW'(1);
      if (byte_cnt == last_cnt) tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Debug sequencer that borrows register-file read port 1 to stream every
// register out over a byte valid/ready link. Outside a dump, read port 1
// passes straight through from decode.
// Optional: define REGDUMP_CHECKSUM_EN to append an XOR checksum byte.
module regfile_dump_ctrl
  import regfile_dump_ctrl_pkg::*;
#(
  parameter int B = 32,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         dump_start,
  input  logic         pipe_idle,
  output logic         stall_req,
  input  logic [W-1:0] id_r_addr1,
  output logic [W-1:0] rf_r_addr1,
  input  logic [B-1:0] rf_r_data1,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         dump_done
);
  // Terminal index NREGS-1 is all ones
  localparam logic [W-1:0] LAST_IDX = '1;

  state_t       state;
  logic [W-1:0] dump_idx;
  logic         ser_load;
  logic         ser_single;
  logic [B-1:0] ser_data;
  logic         last_accept;

  assign rf_r_addr1 = (state != S_IDLE) ? dump_idx : id_r_addr1;

`ifdef REGDUMP_CHECKSUM_EN
  logic [7:0] cksum;
  logic       last_word_done;
  logic [7:0] cksum_final;

  assign last_word_done = last_accept && (state == S_SEND) && (dump_idx == LAST_IDX);
  // Fold in the byte being accepted this cycle so the checksum loads with no gap
  assign cksum_final    = cksum ^ tx_data;
  assign ser_load       = (state == S_LATCH) || last_word_done;
  assign ser_single     = (state != S_LATCH);
  assign ser_data       = (state == S_LATCH) ? rf_r_data1 :
                          (MSB_FIRST ? {cksum_final, {(B-8){1'b0}}} : B'(cksum_final));

  // Running XOR of every accepted register byte, cleared between dumps
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   cksum <= '0;
    else if (state == S_IDLE)                    cksum <= '0;
    else if (state == S_SEND && tx_valid && tx_ready) cksum <= cksum ^ tx_data;
  end
`else
  assign ser_load   = (state == S_LATCH);
  assign ser_single = 1'b0;
  assign ser_data   = rf_r_data1;
`endif

  word_byte_serializer #(.B(B)) u_ser (
    .clk         (clk),
    .reset       (reset),
    .load        (ser_load),
    .single      (ser_single),
    .load_data   (ser_data),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .last_accept (last_accept)
  );

  // Dump sequencer with registered stall/busy/done outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      dump_idx  <= '0;
      stall_req <= 1'b0;
      busy      <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        S_IDLE: if (dump_start) begin
          state     <= S_STALL;
          dump_idx  <= '0;
          stall_req <= 1'b1;
          busy      <= 1'b1;
        end
        S_STALL: if (pipe_idle) state <= S_LATCH;
        S_LATCH: state <= S_SEND;
        S_SEND: if (last_accept) begin
          if (dump_idx == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
            state     <= S_CKSUM;
`else
            state     <= S_DONE;
            dump_done <= 1'b1;
`endif
          end else begin
            dump_idx <= dump_idx + W'(1);
            state    <= S_LATCH;
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        S_CKSUM: if (last_accept) begin
          state     <= S_DONE;
          dump_done <= 1'b1;
        end
`endif
        S_DONE: begin
          state     <= S_IDLE;
          stall_req <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          stall_req <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
